// File: rtl/bram_simple_dual_port.sv
// Simple dual-port block RAM: one write port, one registered read port, one clock.
// Collisions are read-first; rst clears only the output register, never the array.
module bram_simple_dual_port #(
   parameter  int WordLengthBits = 8,
   parameter  int NumWords       = 128,
   localparam int AddressBits    = $clog2(NumWords)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AddressBits-1:0]    address_in,
   input  logic [AddressBits-1:0]    address_out,
   input  logic                      write_enable,
   input  logic [WordLengthBits-1:0] data_in,
   output logic [WordLengthBits-1:0] data_out
);

   logic [WordLengthBits-1:0] mem [NumWords] = '{default: '0};
   logic                      wr_in_range;
   logic                      rd_in_range;

   // Range checks only exist when the depth leaves unused address codes.
   if ((2 ** AddressBits) != NumWords) begin : g_partial
      localparam logic [AddressBits:0] Depth = (AddressBits + 1)'(NumWords);
      assign wr_in_range = ({1'b0, address_in}  < Depth);
      assign rd_in_range = ({1'b0, address_out} < Depth);
   end else begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst && write_enable && wr_in_range) begin
         mem[address_in] <= data_in;
      end
   end

   // Non-blocking read of the array gives the pre-write word on a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (rd_in_range) begin
         data_out <= mem[address_out];
      end else begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_bram_simple_dual_port.sv
// Self-checking bench: directed literal checks plus randomized traffic
// compared every cycle against an array-based model of the RAM.
module tb_bram_simple_dual_port;

   localparam int W  = 8;
   localparam int N  = 128;
   localparam int AB = $clog2(N);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AB-1:0] address_in  = '0;
   logic [AB-1:0] address_out = '0;
   logic          write_enable = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic [W-1:0]  data_out;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   logic [W-1:0] model_mem [N];
   logic [W-1:0] exp_out = '0;

   bram_simple_dual_port #(
      .WordLengthBits(W),
      .NumWords(N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address_in(address_in),
      .address_out(address_out),
      .write_enable(write_enable),
      .data_in(data_in),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < N; i++) model_mem[i] = '0;
   end

   // Model: a reset clears the output, otherwise the read sees the old word.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_out = '0;
      end else begin
         exp_out = (int'(address_out) < N) ? model_mem[address_out] : '0;
         if (write_enable && int'(address_in) < N) model_mem[address_in] = data_in;
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) check("model", data_out, exp_out);
   end

   task automatic step(input logic we, input logic [AB-1:0] ain,
                       input logic [AB-1:0] aout, input logic [W-1:0] din);
      @(negedge clk);
      #1;
      write_enable = we;
      address_in   = ain;
      address_out  = aout;
      data_in      = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", data_out, 8'h00);
      @(negedge clk);
      #1;
      rst = 1'b0;
      checking = 1'b1;

      // basic latency
      step(1'b1, 7'd0, 7'd0, 8'hAA);
      check("init_zero", data_out, 8'h00);
      step(1'b0, 7'd0, 7'd0, 8'h00);
      check("latency", data_out, 8'hAA);

      // read-first collision
      step(1'b1, 7'd0, 7'd0, 8'hAA);
      step(1'b1, 7'd0, 7'd0, 8'hFF);
      check("collision_old", data_out, 8'hAA);
      step(1'b0, 7'd0, 7'd0, 8'h00);
      check("collision_new", data_out, 8'hFF);

      // storage with write_enable low
      step(1'b1, 7'd1, 7'd0, 8'h01);
      step(1'b1, 7'd2, 7'd0, 8'h02);
      step(1'b0, 7'd1, 7'd1, 8'hFF);
      check("store_a1", data_out, 8'h01);
      step(1'b0, 7'd2, 7'd2, 8'hFF);
      check("store_a2", data_out, 8'h02);

      // boundary addresses
      step(1'b1, 7'd0, 7'd0, 8'h01);
      step(1'b1, 7'd127, 7'd0, 8'h02);
      step(1'b0, 7'd0, 7'd0, 8'h00);
      check("bound_a0", data_out, 8'h01);
      step(1'b0, 7'd0, 7'd127, 8'h00);
      check("bound_a127", data_out, 8'h02);

      // concurrent write/read at different addresses
      step(1'b1, 7'd0, 7'd0, 8'h01);
      step(1'b1, 7'd1, 7'd0, 8'h02);
      check("concurrent_rd", data_out, 8'h01);
      step(1'b0, 7'd0, 7'd1, 8'h00);
      check("concurrent_wr", data_out, 8'h02);

      // async reset, blocked writes, contents survive
      step(1'b1, 7'd0, 7'd0, 8'hAA);
      step(1'b0, 7'd0, 7'd0, 8'h00);
      check("pre_reset", data_out, 8'hAA);
      @(negedge clk);
      #1;
      rst = 1'b1;
      write_enable = 1'b1;
      address_in = 7'd0;
      data_in = 8'h33;
      #1;
      check("async_reset", data_out, 8'h00);
      @(posedge clk);
      #1;
      check("reset_hold", data_out, 8'h00);
      step(1'b1, 7'd0, 7'd0, 8'h77);
      check("reset_hold2", data_out, 8'h00);
      @(negedge clk);
      #1;
      rst = 1'b0;
      write_enable = 1'b0;
      address_out = 7'd0;
      @(posedge clk);
      #1;
      check("post_reset", data_out, 8'hAA);

      // randomized traffic, checked against the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         rst          = ($urandom_range(0, 63) == 0);
         write_enable = $urandom_range(0, 1);
         data_in      = W'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            address_in  = AB'($urandom_range(0, 3));
            address_out = AB'($urandom_range(0, 3));
         end else begin
            address_in  = AB'($urandom_range(0, N - 1));
            address_out = AB'($urandom_range(0, N - 1));
         end
      end
      @(negedge clk);
      #1;
      rst = 1'b0;
      write_enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
